// File: rtl/cache_flush_ctrl_pkg.sv
// Shared widths and state encoding for the L1 data-cache flush sequencer.
package cache_flush_ctrl_pkg;

    localparam int FL_WAYS      = 4;
    localparam int FL_IDX_BITS  = 13;
    localparam int FL_TAG_BITS  = 14;
    localparam int FL_LINE_BITS = 256;
    localparam int FL_CNT_BITS  = 16;

    typedef enum logic [2:0] {
        FL_IDLE   = 3'd0,
        FL_ARB    = 3'd1,
        FL_RD_SET = 3'd2,
        FL_LATCH  = 3'd3,
        FL_SEL    = 3'd4,
        FL_WB     = 3'd5,
        FL_UPD    = 3'd6,
        FL_DONE   = 3'd7
    } fl_state_t;

endpackage

// File: rtl/cache_flush_ctrl_lowbit_sel.sv
// Lowest-set-bit priority encoder: picks the first pending way, way 0 first.
module lowbit_sel #(
    parameter int WAYS     = 4,
    parameter int WAY_BITS = $clog2(WAYS)
) (
    input  logic [WAYS-1:0]     bits,
    output logic [WAY_BITS-1:0] way,
    output logic                found
);

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        way   = {WAY_BITS{1'b0}};
        found = |bits;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (bits[i]) begin
                way = WAY_BITS'(i);
            end else begin
                way = way;
            end
        end
    end

endmodule

// File: rtl/cache_flush_ctrl.sv
// Flush/write-back sequencer: walks every set, writes back valid+dirty lines,
// and optionally invalidates each set and resets its pseudo-LRU bits.
module cache_flush_ctrl
    import cache_flush_ctrl_pkg::*;
#(
    parameter int WAYS         = FL_WAYS,
    parameter int IDX_BITS     = FL_IDX_BITS,
    parameter int TAG_BITS     = FL_TAG_BITS,
    parameter int LINE_BITS    = FL_LINE_BITS,
    parameter int MM_ADDR_BITS = TAG_BITS + IDX_BITS,
    parameter int CNT_BITS     = FL_CNT_BITS
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush_req,
    input  logic                      flush_inv,
    output logic                      flush_busy,
    output logic                      flush_done,
    output logic [CNT_BITS-1:0]       wb_count,
    output logic                      dp_req,
    input  logic                      dp_gnt,
    output logic [IDX_BITS-1:0]       arr_idx,
    output logic                      arr_rd,
    input  logic [WAYS-1:0]           valid_in,
    input  logic [WAYS-1:0]           dirty_in,
    input  logic [WAYS*TAG_BITS-1:0]  tag_in,
    input  logic [WAYS*LINE_BITS-1:0] line_in,
    output logic [WAYS-1:0]           dirty_clr,
    output logic [WAYS-1:0]           valid_clr,
    output logic                      lru_rst,
    output logic                      mm_wr_req,
    output logic [MM_ADDR_BITS-1:0]   mm_wr_addr,
    output logic [LINE_BITS-1:0]      mm_wr_data,
    input  logic                      mm_wr_ack
);

    localparam int WAY_BITS = $clog2(WAYS);

    fl_state_t                 state;
    logic                      inv_r;
    logic [WAYS-1:0]           pend_r;
    logic [WAYS*TAG_BITS-1:0]  tag_r;
    logic [WAYS*LINE_BITS-1:0] line_r;
    logic [WAY_BITS-1:0]       wb_way_r;
    logic [WAY_BITS-1:0]       sel_way_s;
    logic                      sel_found_s;

    lowbit_sel #(
        .WAYS     (WAYS),
        .WAY_BITS (WAY_BITS)
    ) u_lowbit_sel (
        .bits  (pend_r),
        .way   (sel_way_s),
        .found (sel_found_s)
    );

    // The dirty clear must land in the ack cycle itself, so it is decoded from
    // the registered way and state rather than delayed a cycle.
    always_comb begin
        dirty_clr = {WAYS{1'b0}};
        if ((state == FL_WB) && mm_wr_ack) begin
            dirty_clr = {{(WAYS-1){1'b0}}, 1'b1} << wb_way_r;
        end else begin
            dirty_clr = {WAYS{1'b0}};
        end
    end

    // Sequencer FSM with registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= FL_IDLE;
            inv_r      <= 1'b0;
            pend_r     <= {WAYS{1'b0}};
            tag_r      <= {(WAYS*TAG_BITS){1'b0}};
            line_r     <= {(WAYS*LINE_BITS){1'b0}};
            wb_way_r   <= {WAY_BITS{1'b0}};
            flush_busy <= 1'b0;
            flush_done <= 1'b0;
            wb_count   <= {CNT_BITS{1'b0}};
            dp_req     <= 1'b0;
            arr_idx    <= {IDX_BITS{1'b0}};
            arr_rd     <= 1'b0;
            valid_clr  <= {WAYS{1'b0}};
            lru_rst    <= 1'b0;
            mm_wr_req  <= 1'b0;
            mm_wr_addr <= {MM_ADDR_BITS{1'b0}};
            mm_wr_data <= {LINE_BITS{1'b0}};
        end else begin
            case (state)
                FL_IDLE: begin
                    if (flush_req) begin
                        inv_r      <= flush_inv;
                        arr_idx    <= {IDX_BITS{1'b0}};
                        wb_count   <= {CNT_BITS{1'b0}};
                        flush_busy <= 1'b1;
                        dp_req     <= 1'b1;
                        state      <= FL_ARB;
                    end else begin
                        state <= FL_IDLE;
                    end
                end
                FL_ARB: begin
                    if (dp_gnt) begin
                        arr_rd <= 1'b1;
                        state  <= FL_RD_SET;
                    end else begin
                        state <= FL_ARB;
                    end
                end
                FL_RD_SET: begin
                    arr_rd <= 1'b0;
                    state  <= FL_LATCH;
                end
                FL_LATCH: begin
                    tag_r  <= tag_in;
                    line_r <= line_in;
                    pend_r <= valid_in & dirty_in;
                    state  <= FL_SEL;
                end
                FL_SEL: begin
                    if (sel_found_s) begin
                        wb_way_r   <= sel_way_s;
                        mm_wr_req  <= 1'b1;
                        mm_wr_addr <= {tag_r[sel_way_s*TAG_BITS +: TAG_BITS], arr_idx};
                        mm_wr_data <= line_r[sel_way_s*LINE_BITS +: LINE_BITS];
                        state      <= FL_WB;
                    end else begin
                        valid_clr <= inv_r ? {WAYS{1'b1}} : {WAYS{1'b0}};
                        lru_rst   <= inv_r;
                        state     <= FL_UPD;
                    end
                end
                FL_WB: begin
                    if (mm_wr_ack) begin
                        pend_r[wb_way_r] <= 1'b0;
                        mm_wr_req        <= 1'b0;
                        if (wb_count != {CNT_BITS{1'b1}}) begin
                            wb_count <= wb_count + CNT_BITS'(1);
                        end else begin
                            wb_count <= wb_count;
                        end
                        state <= FL_SEL;
                    end else begin
                        state <= FL_WB;
                    end
                end
                FL_UPD: begin
                    valid_clr <= {WAYS{1'b0}};
                    lru_rst   <= 1'b0;
                    if (arr_idx == {IDX_BITS{1'b1}}) begin
                        flush_done <= 1'b1;
                        state      <= FL_DONE;
                    end else begin
                        arr_idx <= arr_idx + IDX_BITS'(1);
                        arr_rd  <= 1'b1;
                        state   <= FL_RD_SET;
                    end
                end
                FL_DONE: begin
                    flush_done <= 1'b0;
                    flush_busy <= 1'b0;
                    dp_req     <= 1'b0;
                    state      <= FL_IDLE;
                end
                default: begin
                    flush_busy <= 1'b0;
                    flush_done <= 1'b0;
                    dp_req     <= 1'b0;
                    arr_rd     <= 1'b0;
                    valid_clr  <= {WAYS{1'b0}};
                    lru_rst    <= 1'b0;
                    mm_wr_req  <= 1'b0;
                    state      <= FL_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_flush_ctrl.sv
// Directed bench for cache_flush_ctrl with an 8-set array model and memory ack model.
module tb_cache_flush_ctrl;

    localparam int IDX   = 3;
    localparam int TAGB  = 14;
    localparam int LINEB = 256;
    localparam int W     = 4;
    localparam int CNT   = 16;
    localparam int MMA   = TAGB + IDX;
    localparam logic [1:0] P_CLEAN = 2'd1;
    localparam logic [1:0] P_SET2  = 2'd2;

    logic              clk = 1'b0;
    logic              reset;
    logic              flush_req, flush_inv, flush_busy, flush_done;
    logic [CNT-1:0]    wb_count;
    logic              dp_req, dp_gnt;
    logic [IDX-1:0]    arr_idx;
    logic              arr_rd;
    logic [W-1:0]      valid_in, dirty_in, dirty_clr, valid_clr;
    logic [W*TAGB-1:0] tag_in;
    logic [W*LINEB-1:0] line_in;
    logic              lru_rst, mm_wr_req, mm_wr_ack;
    logic [MMA-1:0]    mm_wr_addr;
    logic [LINEB-1:0]  mm_wr_data;

    always #5 clk = ~clk;

    cache_flush_ctrl #(.IDX_BITS(IDX)) dut (
        .clk(clk), .reset(reset), .flush_req(flush_req), .flush_inv(flush_inv),
        .flush_busy(flush_busy), .flush_done(flush_done), .wb_count(wb_count),
        .dp_req(dp_req), .dp_gnt(dp_gnt), .arr_idx(arr_idx), .arr_rd(arr_rd),
        .valid_in(valid_in), .dirty_in(dirty_in), .tag_in(tag_in), .line_in(line_in),
        .dirty_clr(dirty_clr), .valid_clr(valid_clr), .lru_rst(lru_rst),
        .mm_wr_req(mm_wr_req), .mm_wr_addr(mm_wr_addr), .mm_wr_data(mm_wr_data),
        .mm_wr_ack(mm_wr_ack)
    );

    function automatic logic [TAGB-1:0] tag_of(input logic [2:0] s, input logic [1:0] w);
        if (s == 3'd2 && w == 2'd1) return 14'h0A5;
        else if (s == 3'd2 && w == 2'd3) return 14'h3FF;
        else return {5'd0, w, 4'h6, s};
    endfunction

    function automatic logic [LINEB-1:0] line_of(input logic [2:0] s, input logic [1:0] w);
        return {8{s, w, 3'd0, 8'h5A, ~{s, w, 3'd0}, 8'h3C}};
    endfunction

    // Array and memory models
    logic [3:0] mem_valid [8];
    logic [3:0] mem_dirty [8];
    logic [2:0] rd_idx;
    logic [1:0] preset = 2'd0;
    int         ack_delay = 0;
    int         wait_cnt = 0;
    logic       stray = 1'b0;

    assign valid_in  = mem_valid[rd_idx];
    assign dirty_in  = mem_dirty[rd_idx];
    assign mm_wr_ack = (mm_wr_req && (wait_cnt == ack_delay)) || stray;

    always_comb begin
        tag_in  = '0;
        line_in = '0;
        for (int w = 0; w < W; w++) begin
            tag_in[w*TAGB +: TAGB]    = tag_of(rd_idx, 2'(w));
            line_in[w*LINEB +: LINEB] = line_of(rd_idx, 2'(w));
        end
    end

    always @(posedge clk) begin
        if (arr_rd) rd_idx <= arr_idx;
        if (mm_wr_req && !mm_wr_ack) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
        if (preset != 2'd0) begin
            for (int s = 0; s < 8; s++) begin
                mem_valid[s] <= 4'hF;
                mem_dirty[s] <= 4'h0;
            end
            if (preset == P_SET2) begin
                mem_dirty[2] <= 4'b1010;
                mem_valid[5] <= 4'b1011;
                mem_dirty[5] <= 4'b0100;
            end
        end else begin
            if (dirty_clr != 4'h0) mem_dirty[arr_idx] <= mem_dirty[arr_idx] & ~dirty_clr;
            if (valid_clr != 4'h0) mem_valid[arr_idx] <= mem_valid[arr_idx] & ~valid_clr;
        end
    end

    // Output monitor
    logic [MMA-1:0]   wr_addr_q [$];
    logic [LINEB-1:0] wr_data_q [$];
    logic [3:0]       dclr_q [$];
    int vclr_cnt = 0, lru_cnt = 0, stab_err = 0, gap_err = 0, bad_vclr = 0;
    logic prev_req = 1'b0, prev_ack = 1'b0;
    logic [MMA-1:0]   prev_addr;
    logic [LINEB-1:0] prev_data;

    always @(negedge clk) begin
        if (mm_wr_req && mm_wr_ack) begin
            wr_addr_q.push_back(mm_wr_addr);
            wr_data_q.push_back(mm_wr_data);
        end
        if (mm_wr_req && prev_req && !prev_ack &&
            (mm_wr_addr !== prev_addr || mm_wr_data !== prev_data)) stab_err <= stab_err + 1;
        if (mm_wr_req && prev_ack) gap_err <= gap_err + 1;
        if (dirty_clr != 4'h0) dclr_q.push_back(dirty_clr);
        if (valid_clr == 4'hF) vclr_cnt <= vclr_cnt + 1;
        else if (valid_clr != 4'h0) bad_vclr <= bad_vclr + 1;
        if (lru_rst) lru_cnt <= lru_cnt + 1;
        prev_req  <= mm_wr_req;
        prev_ack  <= mm_wr_req && mm_wr_ack;
        prev_addr <= mm_wr_addr;
        prev_data <= mm_wr_data;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_flush(input logic inv, input int gnt_delay, input logic dup,
                             output int done_e, output int first_rd);
        int e;
        @(negedge clk);
        flush_req = 1'b1;
        flush_inv = inv;
        dp_gnt    = (gnt_delay == 0);
        @(posedge clk); #1;
        flush_req = 1'b0;
        e = 0; done_e = -1; first_rd = -1;
        while (e < 400 && done_e < 0) begin
            @(posedge clk); #1;
            e++;
            if (e == gnt_delay) dp_gnt = 1'b1;
            if (arr_rd && first_rd < 0) first_rd = e;
            if (dup && e == 10) begin flush_req = 1'b1; flush_inv = 1'b1; end
            if (dup && e == 11) flush_req = 1'b0;
            if (flush_done) done_e = e;
        end
    endtask

    typedef struct {
        logic [1:0] pat;
        logic       inv;
        int         gnt_delay;
        int         ack_dly;
        logic       stray_ack;
        logic       dup;
        int         exp_cycle;
        int         exp_wb;
        int         exp_vclr;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int done_e, first_rd, nw0, nd0, vc0, lr0, se0, ge0, bv0, k;
        logic [3:0] anyv;

        reset = 1'b1; flush_req = 1'b0; flush_inv = 1'b0; dp_gnt = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", flush_busy, 1'b0);
        check("rst_done", flush_done, 1'b0);
        check("rst_wb_count", wb_count, 16'd0);
        check("rst_dp_req", dp_req, 1'b0);
        check("rst_arr_idx", arr_idx, 3'd0);
        check("rst_outs", {arr_rd, mm_wr_req, lru_rst, dirty_clr, valid_clr}, 11'd0);
        @(negedge clk);
        reset = 1'b0;

        //           pat      inv   gnt ack stray dup   cyc wb vclr
        vecs[0] = '{P_CLEAN, 1'b0, 0,  0,  1'b0, 1'b0, 34, 0, 0};
        vecs[1] = '{P_SET2,  1'b0, 0,  0,  1'b0, 1'b0, 38, 2, 0};
        vecs[2] = '{P_CLEAN, 1'b1, 0,  0,  1'b0, 1'b0, 34, 0, 8};
        vecs[3] = '{P_CLEAN, 1'b0, 5,  0,  1'b0, 1'b0, 39, 0, 0};
        vecs[4] = '{P_SET2,  1'b0, 0,  3,  1'b0, 1'b1, 44, 2, 0};
        vecs[5] = '{P_SET2,  1'b1, 0,  0,  1'b0, 1'b0, 38, 2, 8};
        vecs[6] = '{P_CLEAN, 1'b0, 0,  0,  1'b1, 1'b0, 34, 0, 0};

        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            preset = vecs[i].pat; ack_delay = vecs[i].ack_dly; stray = vecs[i].stray_ack;
            @(negedge clk);
            preset = 2'd0;
            nw0 = wr_addr_q.size(); nd0 = dclr_q.size();
            vc0 = vclr_cnt; lr0 = lru_cnt; se0 = stab_err; ge0 = gap_err; bv0 = bad_vclr;
            run_flush(vecs[i].inv, vecs[i].gnt_delay, vecs[i].dup, done_e, first_rd);
            check($sformatf("v%0d_done_cycle", i), done_e + 1, vecs[i].exp_cycle);
            check($sformatf("v%0d_first_rd", i), first_rd, 1 + vecs[i].gnt_delay);
            @(posedge clk); #1;
            check($sformatf("v%0d_idle_outs", i), {flush_done, flush_busy, dp_req}, 3'b000);
            repeat (3) @(posedge clk);
            #1;
            check($sformatf("v%0d_wb_count_hold", i), wb_count, vecs[i].exp_wb);
            check($sformatf("v%0d_no_restart", i), flush_busy, 1'b0);
            check($sformatf("v%0d_writes", i), wr_addr_q.size() - nw0, vecs[i].exp_wb);
            check($sformatf("v%0d_dclr_pulses", i), dclr_q.size() - nd0, vecs[i].exp_wb);
            check($sformatf("v%0d_vclr", i), vclr_cnt - vc0, vecs[i].exp_vclr);
            check($sformatf("v%0d_lru", i), lru_cnt - lr0, vecs[i].exp_vclr);
            check($sformatf("v%0d_proto", i), {stab_err - se0, gap_err - ge0, bad_vclr - bv0}, 96'd0);
            if (vecs[i].exp_wb == 2 && wr_addr_q.size() - nw0 == 2 && dclr_q.size() - nd0 == 2) begin
                check($sformatf("v%0d_addr0", i), wr_addr_q[nw0], {14'h0A5, 3'd2});
                check($sformatf("v%0d_addr1", i), wr_addr_q[nw0 + 1], {14'h3FF, 3'd2});
                check($sformatf("v%0d_data0", i), wr_data_q[nw0], line_of(3'd2, 2'd1));
                check($sformatf("v%0d_data1", i), wr_data_q[nw0 + 1], line_of(3'd2, 2'd3));
                check($sformatf("v%0d_dclr0", i), dclr_q[nd0], 4'b0010);
                check($sformatf("v%0d_dclr1", i), dclr_q[nd0 + 1], 4'b1000);
                check($sformatf("v%0d_set2_clean", i), mem_dirty[2], 4'h0);
                check($sformatf("v%0d_set5_dirty_kept", i), mem_dirty[5], 4'b0100);
            end
            anyv = 4'h0;
            for (int s = 0; s < 8; s++) anyv = anyv | mem_valid[s];
            check($sformatf("v%0d_valid_after", i), anyv, vecs[i].inv ? 4'h0 : 4'hF);
            stray = 1'b0;
        end

        // Reset while a write-back is waiting for its ack.
        @(negedge clk);
        preset = P_SET2; ack_delay = 20;
        @(negedge clk);
        preset = 2'd0;
        flush_req = 1'b1; flush_inv = 1'b0;
        @(posedge clk); #1;
        flush_req = 1'b0;
        k = 0;
        while (!mm_wr_req && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        check("rst_reach_wb", mm_wr_req, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_mid_outs", {mm_wr_req, dp_req, flush_busy}, 3'b000);
        @(negedge clk);
        reset = 1'b0; ack_delay = 0;
        check("rst_mid_dirty_kept", mem_dirty[2], 4'b1010);
        @(negedge clk);
        flush_req = 1'b1;
        @(posedge clk); #1;
        flush_req = 1'b0;
        check("restart_idx_cnt", {arr_idx, wb_count}, 19'd0);
        check("restart_dp_req", dp_req, 1'b1);
        k = 0;
        while (!flush_done && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        check("restart_done_cycle", k + 1, 38);
        check("restart_wb_count", wb_count, 16'd2);
        check("restart_set2_clean", mem_dirty[2], 4'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
